// File: rtl/entry_stack.sv
`default_nettype none
// entry_stack: DEPTH-entry push-down operand stack with set/clear, indexed read,
// full/empty status and registered overflow/underflow pulses.
module entry_stack #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int SET_VAL = 1
) (
  input  logic                       CLK,
  input  logic                       CLR_N,
  input  logic                       clr,
  input  logic                       set,
  input  logic                       enter,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           D,
  input  logic [$clog2(DEPTH)-1:0]   sel,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Q_sel,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int               SW       = $clog2(DEPTH);
  localparam int               CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [SW:0]      SEL_LIM  = (SW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] SET_W    = WIDTH'(SET_VAL);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             cnt_zero, cnt_full;

  assign cnt_zero = (count_q == '0);
  assign cnt_full = (count_q == CNT_FULL);

  // Single priority chain: clr > set > enter&pop > enter > pop > hold.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
      count_d = '0;
    end else if (set) begin
      entry_d[0] = SET_W;
      if (cnt_zero) count_d = CNT_ONE;
    end else if (enter && pop && !cnt_zero) begin
      entry_d[0] = D;
    end else if (enter) begin
      for (int i = DEPTH - 1; i >= 1; i--) entry_d[i] = entry_q[i-1];
      entry_d[0] = D;
      if (cnt_full) ovf_d = 1'b1;
      else          count_d = count_q + CNT_ONE;
    end else if (pop) begin
      if (cnt_zero) begin
        unf_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
        entry_d[DEPTH-1] = '0;
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Out-of-range select (non power-of-two DEPTH) reads as zero.
  always_comb begin
    Q_sel = '0;
    if ({1'b0, sel} < SEL_LIM) Q_sel = entry_q[sel];
  end

  assign Q         = entry_q[0];
  assign count     = count_q;
  assign full      = cnt_full;
  assign empty     = cnt_zero;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_entry_stack.sv
`default_nettype none
// Directed self-checking bench for entry_stack (DEPTH=4 main instance, DEPTH=3 select-read instance).
module tb_entry_stack;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic       a_clr = 0, a_set = 0, a_enter = 0, a_pop = 0;
  logic [7:0] a_D = 0;
  logic [1:0] a_sel = 0;
  logic [7:0] a_Q, a_Q_sel;
  logic [2:0] a_count;
  logic       a_full, a_empty, a_ovf, a_unf;

  logic       b_clr = 0, b_set = 0, b_enter = 0, b_pop = 0;
  logic [7:0] b_D = 0;
  logic [1:0] b_sel = 0;
  logic [7:0] b_Q, b_Q_sel;
  logic [1:0] b_count;
  logic       b_full, b_empty, b_ovf, b_unf;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  entry_stack #(.WIDTH(8), .DEPTH(4), .SET_VAL(1)) u_a (
    .CLK(CLK), .CLR_N(CLR_N), .clr(a_clr), .set(a_set), .enter(a_enter), .pop(a_pop),
    .D(a_D), .sel(a_sel), .Q(a_Q), .Q_sel(a_Q_sel), .count(a_count),
    .full(a_full), .empty(a_empty), .overflow(a_ovf), .underflow(a_unf)
  );

  entry_stack #(.WIDTH(8), .DEPTH(3), .SET_VAL(1)) u_b (
    .CLK(CLK), .CLR_N(CLR_N), .clr(b_clr), .set(b_set), .enter(b_enter), .pop(b_pop),
    .D(b_D), .sel(b_sel), .Q(b_Q), .Q_sel(b_Q_sel), .count(b_count),
    .full(b_full), .empty(b_empty), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_idle();
    a_clr = 0; a_set = 0; a_enter = 0; a_pop = 0;
  endtask

  task automatic a_push(input logic [7:0] v);
    a_idle(); a_enter = 1; a_D = v; step();
  endtask

  task automatic a_pop1();
    a_idle(); a_pop = 1; step();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_Q", a_Q, 0);
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    #1 CLR_N = 1;

    // Push to full, then overflow
    a_push(8'h11); chk("push1_Q", a_Q, 8'h11); chk("push1_cnt", a_count, 1);
    a_push(8'h22); chk("push2_Q", a_Q, 8'h22);
    a_push(8'h33); chk("push3_Q", a_Q, 8'h33);
    a_push(8'h44);
    a_sel = 2'd3; #1;
    chk("full_Q", a_Q, 8'h44);
    chk("full_e3", a_Q_sel, 8'h11);
    chk("full_flag", a_full, 1);
    chk("full_cnt", a_count, 4);
    chk("full_ovf", a_ovf, 0);
    a_push(8'h55);
    chk("ovf_Q", a_Q, 8'h55);
    chk("ovf_e3", a_Q_sel, 8'h22);
    chk("ovf_cnt", a_count, 4);
    chk("ovf_pulse", a_ovf, 1);
    a_push(8'h66);
    chk("ovf_held", a_ovf, 1);
    chk("ovf2_e3", a_Q_sel, 8'h33);
    a_idle(); step();
    chk("ovf_drop", a_ovf, 0);
    chk("hold_Q", a_Q, 8'h66);

    // Async reset mid-cycle with count=3
    a_pop1();
    chk("pre_rst_cnt", a_count, 3);
    chk("pre_rst_Q", a_Q, 8'h55);
    a_idle(); a_enter = 1; a_D = 8'hEE;
    #2 CLR_N = 0;
    #1;
    chk("arst_Q", a_Q, 0);
    chk("arst_cnt", a_count, 0);
    chk("arst_empty", a_empty, 1);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_unf", a_unf, 0);
    a_idle();
    #1 CLR_N = 1;

    // Pop to underflow
    a_push(8'h11); a_push(8'h22); a_push(8'h33); a_push(8'h44);
    a_pop1(); chk("pop1_Q", a_Q, 8'h33);
    a_pop1(); chk("pop2_Q", a_Q, 8'h22);
    a_pop1(); chk("pop3_Q", a_Q, 8'h11); chk("pop3_cnt", a_count, 1);
    a_pop1(); chk("pop4_Q", a_Q, 8'h00); chk("pop4_empty", a_empty, 1);
    chk("pop4_unf", a_unf, 0);
    a_pop1();
    chk("unf_pulse", a_unf, 1);
    chk("unf_cnt", a_count, 0);
    a_sel = 2'd1; #1; chk("unf_e1", a_Q_sel, 0);
    a_idle(); step();
    chk("unf_drop", a_unf, 0);

    // Simultaneous enter & pop
    a_push(8'hB0); a_push(8'hA0);
    a_idle(); a_enter = 1; a_pop = 1; a_D = 8'hC0; step();
    chk("ep_Q", a_Q, 8'hC0);
    chk("ep_e1", a_Q_sel, 8'hB0);
    chk("ep_cnt", a_count, 2);
    a_idle(); a_clr = 1; step();
    chk("clr_cnt", a_count, 0);
    chk("clr_e1", a_Q_sel, 0);
    a_idle(); a_enter = 1; a_pop = 1; a_D = 8'h07; step();
    chk("ep0_Q", a_Q, 8'h07);
    chk("ep0_cnt", a_count, 1);
    chk("ep0_unf", a_unf, 0);

    // Priority
    a_idle(); a_clr = 1; step();
    a_idle(); a_set = 1; step();
    chk("set0_Q", a_Q, 8'h01);
    chk("set0_cnt", a_count, 1);
    a_idle(); a_clr = 1; a_set = 1; a_enter = 1; a_D = 8'h5A; step();
    chk("cse_Q", a_Q, 0);
    chk("cse_cnt", a_count, 0);
    a_push(8'h05);
    a_idle(); a_set = 1; a_enter = 1; a_D = 8'h09; step();
    chk("se_Q", a_Q, 8'h01);
    chk("se_cnt", a_count, 1);
    chk("se_ovf", a_ovf, 0);
    a_idle(); a_push(8'h0F);
    a_idle(); a_set = 1; step();
    chk("set2_Q", a_Q, 8'h01);
    chk("set2_e1", a_Q_sel, 8'h01);
    chk("set2_cnt", a_count, 2);
    a_idle();

    // Select read on DEPTH=3 instance
    b_enter = 1;
    b_D = 8'd3; step();
    b_D = 8'd2; step();
    b_D = 8'd1; step();
    b_enter = 0;
    chk("b_full", b_full, 1);
    chk("b_cnt", b_count, 3);
    b_sel = 2'd0; #1; chk("bsel0", b_Q_sel, 8'd1);
    b_sel = 2'd1; #1; chk("bsel1", b_Q_sel, 8'd2);
    b_sel = 2'd2; #1; chk("bsel2", b_Q_sel, 8'd3);
    b_sel = 2'd3; #1; chk("bsel3", b_Q_sel, 8'd0);
    b_enter = 1; b_D = 8'd4; step();
    b_enter = 0;
    chk("b_ovf", b_ovf, 1);
    b_sel = 2'd2; #1; chk("b_ovf_e2", b_Q_sel, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
